// File: rtl/cpu_run_ctrl.sv
// Run controller sitting in front of the processor core: it pulses the core's start
// input, counts cycles until halt, aborts on a cycle limit and signals completion.
module cpu_run_ctrl #(
  parameter int CNT_W        = 16,
  parameter int START_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic             halt,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {IDLE, START, RUN, ABORT, DONE} state_t;

  // The counter is loaded with START_CYCLES-1 so that start stays high for exactly
  // START_CYCLES cycles, counting the cycle of the loading edge.
  localparam logic [3:0]       SC_LOAD = 4'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] limit;
  logic [3:0]       sc_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      start       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
      limit       <= '0;
      sc_cnt      <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state       <= START;
          start       <= 1'b1;
          busy        <= 1'b1;
          limit       <= max_cycles;
          cycle_count <= '0;
          timed_out   <= 1'b0;
          sc_cnt      <= SC_LOAD;
        end
        START: begin
          if (sc_cnt == 4'd0) begin
            state <= RUN;
            start <= 1'b0;
          end else begin
            sc_cnt <= sc_cnt - 4'd1;
          end
        end
        RUN: begin
          // A halt on the same edge as the limit hit takes priority.
          if (halt) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (limit != '0 && cycle_count == limit) begin
            state     <= ABORT;
            start     <= 1'b1;
            timed_out <= 1'b1;
            sc_cnt    <= SC_LOAD;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + CNT_ONE;
          end
        end
        ABORT: begin
          if (sc_cnt == 4'd0) begin
            state <= DONE;
            start <= 1'b0;
            done  <= 1'b1;
          end else begin
            sc_cnt <= sc_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        go, halt;
  logic [15:0] max_cycles;
  logic        start, busy, done, timed_out;
  logic [15:0] cycle_count;

  logic        go4, halt4;
  logic [3:0]  max4;
  logic        start4, busy4, done4, to4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.CNT_W(16), .START_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .go(go), .max_cycles(max_cycles), .halt(halt),
    .start(start), .busy(busy), .done(done), .timed_out(timed_out), .cycle_count(cycle_count)
  );

  cpu_run_ctrl #(.CNT_W(4), .START_CYCLES(2)) dut4 (
    .clk(clk), .reset(reset), .go(go4), .max_cycles(max4), .halt(halt4),
    .start(start4), .busy(busy4), .done(done4), .timed_out(to4), .cycle_count(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // go pulse, then advance to the first RUN cycle (count 0)
  task automatic launch(input logic [15:0] lim, input logic h);
    max_cycles = lim; halt = h; go = 1'b1;
    cyc();
    go = 1'b0;
    cyc(2);
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; halt = 1'b0; max_cycles = '0;
    go4 = 1'b0; halt4 = 1'b0; max4 = '0;
    cyc(2);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_to", timed_out, 0);
    chk("rst_cnt", cycle_count, 0);
    reset = 1'b1;
    cyc();

    // basic run
    go = 1'b1; max_cycles = 16'd0;
    cyc();
    go = 1'b0;
    chk("basic_start_c1", start, 1);
    chk("basic_busy_c1", busy, 1);
    cyc();
    chk("basic_start_c2", start, 1);
    cyc();
    chk("basic_start_run", start, 0);
    chk("basic_cnt0", cycle_count, 0);
    cyc(10);
    chk("basic_cnt10", cycle_count, 10);
    chk("basic_nodone", done, 0);
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    chk("basic_done", done, 1);
    chk("basic_cnt", cycle_count, 10);
    chk("basic_to", timed_out, 0);
    chk("basic_busy_done", busy, 1);
    cyc();
    chk("basic_done_clr", done, 0);
    chk("basic_busy_clr", busy, 0);

    // timeout
    launch(16'd5, 1'b0);
    max_cycles = 16'd0;  // must not affect the running run
    cyc(5);
    chk("to_cnt5", cycle_count, 5);
    chk("to_start_run", start, 0);
    cyc();
    chk("to_abort_start1", start, 1);
    chk("to_flag", timed_out, 1);
    chk("to_cnt_hold", cycle_count, 5);
    cyc();
    chk("to_abort_start2", start, 1);
    chk("to_nodone", done, 0);
    cyc();
    chk("to_done", done, 1);
    chk("to_start_off", start, 0);
    cyc();
    chk("to_idle_busy", busy, 0);
    chk("to_idle_flag", timed_out, 1);
    chk("to_idle_cnt", cycle_count, 5);

    // go ignored while busy; fresh go clears count and flag
    go = 1'b1; max_cycles = 16'd0;
    cyc();
    go = 1'b0;
    chk("ign_to_clr", timed_out, 0);
    chk("ign_cnt_clr", cycle_count, 0);
    cyc(2);
    cyc(3);
    chk("ign_cnt3", cycle_count, 3);
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("ign_start", start, 0);
    chk("ign_cnt4", cycle_count, 4);
    cyc();
    chk("ign_start2", start, 0);
    chk("ign_cnt5", cycle_count, 5);
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    chk("ign_done", done, 1);
    chk("ign_cnt_fin", cycle_count, 5);
    cyc();

    // halt and limit on the same edge: halt wins
    launch(16'd5, 1'b0);
    cyc(5);
    chk("sim_cnt5", cycle_count, 5);
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    chk("sim_done", done, 1);
    chk("sim_start", start, 0);
    chk("sim_to", timed_out, 0);
    chk("sim_cnt", cycle_count, 5);
    cyc();
    chk("sim_busy", busy, 0);

    // asynchronous reset mid-RUN
    launch(16'd0, 1'b0);
    cyc(7);
    chk("ar_cnt7", cycle_count, 7);
    #2 reset = 1'b0;
    #1;
    chk("ar_start", start, 0);
    chk("ar_busy", busy, 0);
    chk("ar_cnt", cycle_count, 0);
    chk("ar_to", timed_out, 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("ar_nodone", done, 0);
      chk("ar_idle", busy, 0);
    end

    // asynchronous reset during START drops start between edges
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("ars_start_hi", start, 1);
    #2 reset = 1'b0;
    #1;
    chk("ars_start_lo", start, 0);
    #1 reset = 1'b1;
    cyc(2);
    chk("ars_idle", busy, 0);

    // core already halted
    launch(16'd0, 1'b1);
    chk("pre_nodone", done, 0);
    cyc();
    halt = 1'b0;
    chk("pre_done", done, 1);
    chk("pre_cnt", cycle_count, 0);
    cyc();

    // saturation with a 4-bit counter
    go4 = 1'b1; max4 = 4'd0;
    cyc();
    go4 = 1'b0;
    cyc(2);
    cyc(20);
    chk("sat_cnt", cnt4, 15);
    chk("sat_nodone", done4, 0);
    chk("sat_to", to4, 0);
    halt4 = 1'b1;
    cyc();
    halt4 = 1'b0;
    chk("sat_done", done4, 1);
    chk("sat_cnt_fin", cnt4, 15);
    cyc();
    chk("sat_busy", busy4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
